// File: rtl/ddr_wr_burst_master_if.sv
// Bus interface for ddr_wr_burst_master: FIFO read port plus the AXI-style
// AW / W / B channels toward the DDR controller.
// master modport = the burst master, slave modport = FIFO + controller side.
interface ddr_wr_burst_master_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 28,
  parameter int LEVEL_WIDTH = 11
);
  // FIFO read port
  logic                   fifo_rd_en;
  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic                   fifo_rd_empty;
  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level;
  // Write address channel
  logic [ADDR_WIDTH-1:0]  awaddr;
  logic [7:0]             awlen;
  logic                   awvalid;
  logic                   awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]  wdata;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  // Write response channel
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
    output awaddr, awlen, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
    input  awaddr, awlen, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ddr_wr_burst_master.sv
// ddr_wr_burst_master: drains 128-bit words from the write FIFO and issues
// them as incrementing write bursts. A burst starts only once the FIFO level
// covers the whole burst. Single clock domain (rd_clk).
// Optional feature: define DDR_WR_BURST_CNT_EN to build the saturating
// completed-burst counter on burst_cnt; otherwise burst_cnt is tied to 0.
module ddr_wr_burst_master #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 28,
  parameter int LEVEL_WIDTH = 11,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WIDTH = 20
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [FRAME_WIDTH-1:0] frame_beats,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_err,
  output logic [15:0]            burst_cnt,
  ddr_wr_burst_master_if.master  bus
);
  localparam int BL_W  = $clog2(BURST_LEN + 1);
  localparam int CMP_W = LEVEL_WIDTH + BL_W;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [BL_W-1:0] ONE = BL_W'(1);

  typedef enum logic [2:0] {IDLE, WAIT_LVL, ADDR, DATA, RESP} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, awaddr_q, awaddr_d;
  logic [7:0]             awlen_q, awlen_d;
  logic                   awvalid_q, awvalid_d;
  logic                   bready_q, bready_d;
  logic [FRAME_WIDTH-1:0] remain_q, remain_d;
  logic [BL_W-1:0]        blen_q, blen_d;
  logic [BL_W-1:0]        rd_issued_q, rd_issued_d;
  logic [BL_W-1:0]        beat_q, beat_d;
  logic [DATA_WIDTH-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]             buf_cnt_q, buf_cnt_d;
  logic                   inflight_q, inflight_d;
  logic                   busy_q, busy_d, done_q, done_d, wr_err_q, wr_err_d;

  logic                   rd_en, wvalid, pop, last_beat;
  logic [1:0]             occ;
  logic [DATA_WIDTH-1:0]  head, e0, e1;

  // Beats in the next burst: min(BURST_LEN, remaining words).
  function automatic logic [BL_W-1:0] burst_size(input logic [FRAME_WIDTH-1:0] rem);
    if (rem >= FRAME_WIDTH'(BURST_LEN)) return BL_W'(BURST_LEN);
    return BL_W'(rem);
  endfunction

  // Next-state logic: FSM, 2-entry output buffer and read-issue control.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    bready_d    = bready_q;
    remain_d    = remain_q;
    blen_d      = blen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_err_d    = wr_err_q;

    // Occupied buffer entries plus the read whose data arrives this cycle.
    occ       = buf_cnt_q + {1'b0, inflight_q};
    rd_en     = (state_q == ADDR || state_q == DATA) && (occ < 2'd2) &&
                (rd_issued_q != blen_q) && !bus.fifo_rd_empty;
    // The word arriving from the FIFO counts as buffered so it can leave
    // in the same cycle; this is what sustains one beat per cycle.
    wvalid    = (state_q == DATA) && ((buf_cnt_q != 2'd0) || inflight_q);
    head      = (buf_cnt_q != 2'd0) ? buf0_q :
                (inflight_q ? bus.fifo_rd_data : '0);
    last_beat = (beat_q == blen_q - ONE);
    pop       = wvalid && bus.wready;

    // Ordered contents: stored entries first, then the arriving word.
    e0 = (buf_cnt_q != 2'd0) ? buf0_q : bus.fifo_rd_data;
    e1 = (buf_cnt_q == 2'd2) ? buf1_q : bus.fifo_rd_data;
    if (pop) begin
      buf0_d    = e1;
      buf1_d    = buf1_q;
      buf_cnt_d = occ - 2'd1;
    end else begin
      buf0_d    = e0;
      buf1_d    = e1;
      buf_cnt_d = occ;
    end
    inflight_d  = rd_en;
    rd_issued_d = rd_issued_q + BL_W'(rd_en);
    beat_d      = beat_q + BL_W'(pop);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          wr_err_d = 1'b0;
          if (frame_beats != '0) begin
            state_d     = WAIT_LVL;
            addr_d      = base_addr;
            remain_d    = frame_beats;
            blen_d      = burst_size(frame_beats);
            busy_d      = 1'b1;
            rd_issued_d = '0;
            beat_d      = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_LVL: begin
        if (CMP_W'(bus.fifo_rd_water_level) >= CMP_W'(blen_q)) begin
          state_d   = ADDR;
          awvalid_d = 1'b1;
          awaddr_d  = addr_q;
          awlen_d   = 8'(blen_q - ONE);
        end
      end
      ADDR: begin
        if (bus.awready) begin
          state_d   = DATA;
          awvalid_d = 1'b0;
        end
      end
      DATA: begin
        if (pop && last_beat) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.bvalid) begin
          bready_d = 1'b0;
          wr_err_d = wr_err_q | (bus.bresp != 2'b00);
          remain_d = remain_q - FRAME_WIDTH'(blen_q);
          addr_d   = addr_q + ADDR_WIDTH'(blen_q) * ADDR_WIDTH'(BYTES);
          if (remain_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d     = WAIT_LVL;
            blen_d      = burst_size(remain_d);
            rd_issued_d = '0;
            beat_d      = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any burst and discards buffered words.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      remain_q    <= '0;
      blen_q      <= '0;
      rd_issued_q <= '0;
      beat_q      <= '0;
      // NOTE: the data buffer is reset too, so no stale word survives an abort.
      buf0_q      <= '0;
      buf1_q      <= '0;
      buf_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      bready_q    <= bready_d;
      remain_q    <= remain_d;
      blen_q      <= blen_d;
      rd_issued_q <= rd_issued_d;
      beat_q      <= beat_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      buf_cnt_q   <= buf_cnt_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
    end
  end

`ifdef DDR_WR_BURST_CNT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic        start_acc, b_hs;

  assign start_acc = (state_q == IDLE) && start;
  assign b_hs      = (state_q == RESP) && bus.bvalid;

  // Completed-burst counter: cleared by an accepted start, saturating.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (start_acc)                       burst_cnt_d = '0;
    else if (b_hs && burst_cnt_q != '1)  burst_cnt_d = burst_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end

  assign burst_cnt = burst_cnt_q;
`else
  assign burst_cnt = 16'h0000;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign wr_err         = wr_err_q;
  assign bus.fifo_rd_en = rd_en;
  assign bus.awaddr     = awaddr_q;
  assign bus.awlen      = awlen_q;
  assign bus.awvalid    = awvalid_q;
  assign bus.wdata      = head;
  assign bus.wvalid     = wvalid;
  assign bus.wlast      = wvalid && last_beat;
  assign bus.bready     = bready_q;
endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Testbench for ddr_wr_burst_master: FIFO + DDR controller models driven with
// $urandom, frames checked against a burst-list / word-order reference model.
module tb_ddr_wr_burst_master;
  localparam int DW = 128, AW = 28, LW = 11, BL = 16, FW = 20;
  localparam int BYTES = DW / 8;

  logic          rd_clk = 1'b0;
  logic          rd_rst, start;
  logic [AW-1:0] base_addr;
  logic [FW-1:0] frame_beats;
  logic          busy, done, wr_err;
  logic [15:0]   burst_cnt;

  ddr_wr_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEVEL_WIDTH(LW)) bus ();

  ddr_wr_burst_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .FRAME_WIDTH(FW)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .base_addr(base_addr),
    .frame_beats(frame_beats), .busy(busy), .done(done), .wr_err(wr_err),
    .burst_cnt(burst_cnt), .bus(bus)
  );

  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- shared bench state ----------------
  int             cyc = 0;
  logic [DW-1:0]  fifo_q[$], pw_log[$];
  bit             fill_en = 0;
  int             aw_delay = 0, wr_pct = 100, err_idx = -1, b_idx = 0, aw_wait = 0;
  bit             b_pend = 0;
  // monitor outputs
  bit             rd_fire_s, wlast_hs_s, b_hs_s;
  logic [AW-1:0]  aw_addr_log[$];
  logic [7:0]     aw_len_log[$];
  logic [DW-1:0]  w_data_log[$];
  bit             w_last_log[$];
  int             rd_cnt, aw_seen, done_cnt, done_cyc, last_b_cyc, stab_err, max_outst;
  int             start_cyc, first_busy, first_aw, first_rd, first_w;
  bit             prev_stall;
  logic [DW-1:0]  prev_wd;
  logic           prev_wl;

  initial forever begin
    @(posedge rd_clk);
    cyc++;
  end

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_word();
    logic [DW-1:0] w;
    w = rand_word();
    fifo_q.push_back(w);
    pw_log.push_back(w);
  endtask

  task automatic fifo_sync();
    bus.fifo_rd_water_level = LW'(fifo_q.size());
    bus.fifo_rd_empty       = (fifo_q.size() == 0);
  endtask

  // FIFO and controller models: drive inputs 1 time unit after each edge.
  initial begin
    bus.fifo_rd_data = '0; bus.awready = 0; bus.wready = 0;
    bus.bresp = 2'b00; bus.bvalid = 0;
    fifo_sync();
    forever begin
      @(posedge rd_clk); #1;
      if (rd_fire_s && fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
      if (fill_en && fifo_q.size() < 64 && $urandom_range(1) == 1) push_word();
      fifo_sync();
      if (bus.awvalid) begin
        bus.awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        bus.awready = 0;
        aw_wait = 0;
      end
      bus.wready = ($urandom_range(99) < wr_pct);
      if (b_hs_s) bus.bvalid = 0;
      if (wlast_hs_s) b_pend = 1;
      if (b_pend && !bus.bvalid) begin
        bus.bvalid = 1;
        bus.bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
        b_idx++;
        b_pend = 0;
      end
    end
  end

  // Monitor: samples DUT outputs on the falling edge.
  initial forever begin
    @(negedge rd_clk);
    rd_fire_s = 0; wlast_hs_s = 0; b_hs_s = 0;
    if (rd_rst) prev_stall = 0;
    else begin
      if (start) start_cyc = cyc;
      if (busy && first_busy < 0) first_busy = cyc;
      if (bus.awvalid) begin
        aw_seen++;
        if (first_aw < 0) first_aw = cyc;
        if (bus.awready) begin
          aw_addr_log.push_back(bus.awaddr);
          aw_len_log.push_back(bus.awlen);
        end
      end
      if (bus.fifo_rd_en) begin
        rd_fire_s = 1; rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.wvalid && first_w < 0) first_w = cyc;
      if (prev_stall && !(bus.wvalid && bus.wdata === prev_wd && bus.wlast === prev_wl))
        stab_err++;
      prev_stall = bus.wvalid && !bus.wready;
      prev_wd = bus.wdata; prev_wl = bus.wlast;
      if (bus.wvalid && bus.wready) begin
        w_data_log.push_back(bus.wdata);
        w_last_log.push_back(bus.wlast);
        if (bus.wlast) wlast_hs_s = 1;
      end
      if (rd_cnt - w_data_log.size() > max_outst) max_outst = rd_cnt - w_data_log.size();
      if (bus.bvalid && bus.bready) begin
        b_hs_s = 1; last_b_cyc = cyc;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
      end
    end
  end

  // Main-thread sync point: after the edge and after the model drivers.
  task automatic tick();
    @(posedge rd_clk); #2;
  endtask

  task automatic frame_setup(input int prefill, input bit refill, input int awd,
                             input int wpct, input int eidx);
    fifo_q.delete(); pw_log.delete();
    for (int i = 0; i < prefill; i++) push_word();
    fifo_sync();
    fill_en = refill; aw_delay = awd; wr_pct = wpct; err_idx = eidx; b_idx = 0;
    aw_addr_log.delete(); aw_len_log.delete(); w_data_log.delete(); w_last_log.delete();
    rd_cnt = 0; aw_seen = 0; done_cnt = 0; done_cyc = -1; last_b_cyc = -1;
    stab_err = 0; max_outst = 0;
    start_cyc = -1; first_busy = -1; first_aw = -1; first_rd = -1; first_w = -1;
  endtask

  task automatic frame_start(input logic [AW-1:0] base, input int n);
    base_addr = base; frame_beats = FW'(n); start = 1;
    tick();
    start = 0;
  endtask

  // Reference model: burst list from min(BL, remaining), words in push order.
  task automatic frame_finish(input string nm, input logic [AW-1:0] base, input int n,
                              input int eidx);
    int k = 0, bl, rem = n, w;
    bit exp_last[$];
    logic [AW-1:0] a = base;
    while (done_cnt == 0 && k < 5000) begin tick(); k++; end
    check({nm, "_done_seen"}, done_cnt != 0, 1);
    repeat (4) tick();
    k = 0;
    while (rem > 0) begin
      bl = (rem < BL) ? rem : BL;
      if (k < aw_addr_log.size()) begin
        check({nm, "_awaddr"}, aw_addr_log[k], a);
        check({nm, "_awlen"}, aw_len_log[k], 8'(bl - 1));
      end
      for (int j = 0; j < bl; j++) exp_last.push_back(j == bl - 1);
      a = a + AW'(bl * BYTES);
      rem -= bl; k++;
    end
    check({nm, "_aw_count"}, aw_addr_log.size(), k);
    check({nm, "_w_count"}, w_data_log.size(), n);
    w = (w_data_log.size() < n) ? w_data_log.size() : n;
    for (int i = 0; i < w; i++) begin
      check({nm, "_wdata"}, w_data_log[i], pw_log[i]);
      check({nm, "_wlast"}, w_last_log[i], exp_last[i]);
    end
    check({nm, "_rd_en_count"}, rd_cnt, n);
    check({nm, "_done_once"}, done_cnt, 1);
    check({nm, "_done_after_b"}, done_cyc, last_b_cyc + 1);
    check({nm, "_busy_end"}, busy, 0);
    check({nm, "_wr_err"}, wr_err, (eidx >= 0 && eidx < k));
`ifdef DDR_WR_BURST_CNT_EN
    check({nm, "_burst_cnt"}, burst_cnt, k);
`else
    check({nm, "_burst_cnt"}, burst_cnt, 0);
`endif
    check({nm, "_w_stable"}, stab_err, 0);
    check({nm, "_outstanding_le2"}, max_outst <= 2, 1);
  endtask

  task automatic run_frame(input string nm, input logic [AW-1:0] base, input int n,
                           input int prefill, input bit refill, input int awd,
                           input int wpct, input int eidx);
    frame_setup(prefill, refill, awd, wpct, eidx);
    frame_start(base, n);
    frame_finish(nm, base, n, eidx);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, n, nb, eidx;
    logic [AW-1:0] base;
    rd_rst = 1; start = 0; base_addr = '0; frame_beats = '0;
    #1;
    check("reset_ctrl", {busy, done, wr_err, burst_cnt, bus.fifo_rd_en, bus.awaddr,
                         bus.awlen, bus.awvalid, bus.wlast, bus.wvalid, bus.bready}, 0);
    check("reset_wdata", bus.wdata, 0);
    repeat (3) tick();
    rd_rst = 0;
    tick();

    // Two full bursts with first-transaction timing.
    run_frame("f32", AW'('h1000), 32, 64, 0, 0, 100, -1);
    check("t_busy", first_busy, start_cyc + 1);
    check("t_awvalid", first_aw, start_cyc + 2);
    check("t_rd_en", first_rd, start_cyc + 2);
    check("t_wvalid", first_w, start_cyc + 3);

    // Short tail burst.
    run_frame("f20", AW'(0), 20, 20, 0, 0, 100, -1);

    // Level gate: 15 words never start a 16-beat burst.
    frame_setup(15, 0, 0, 100, -1);
    frame_start(AW'('h2000), 16);
    repeat (30) tick();
    check("lvl15_no_aw", aw_seen, 0);
    push_word();
    fifo_sync();
    k = cyc;
    frame_finish("lvl16", AW'('h2000), 16, -1);
    check("lvl16_aw_delay", first_aw, k + 1);

    // Back-pressure: wready 50%, awready delayed by 5.
    run_frame("bp", AW'('h40000), 48, 0, 1, 5, 50, -1);

    // Error response on first burst, then cleared by the next start.
    run_frame("err", AW'('h3000), 32, 64, 0, 0, 100, 0);
    run_frame("err_clr", AW'('h3000), 16, 16, 0, 0, 100, -1);

    // Reset mid-burst.
    frame_setup(64, 1, 0, 100, -1);
    frame_start(AW'('h5000), 32);
    k = 0;
    while (w_data_log.size() < 5 && k < 200) begin tick(); k++; end
    check("rst_reached_data", w_data_log.size() >= 5, 1);
    rd_rst = 1;
    b_pend = 0; bus.bvalid = 0;
    #1;
    check("rst_async_ctrl", {busy, done, wr_err, burst_cnt, bus.fifo_rd_en, bus.awaddr,
                             bus.awlen, bus.awvalid, bus.wlast, bus.wvalid, bus.bready}, 0);
    check("rst_async_wdata", bus.wdata, 0);
    repeat (3) tick();
    rd_rst = 0;
    repeat (5) tick();
    check("rst_no_done", done_cnt, 0);
    run_frame("post_rst", AW'('h6000), 32, 0, 1, 0, 100, -1);

    // Zero-length frame: done next cycle, busy never set.
    frame_setup(0, 0, 0, 100, -1);
    frame_start(AW'('h7000), 0);
    repeat (5) tick();
    check("zero_done_once", done_cnt, 1);
    check("zero_done_cyc", done_cyc, start_cyc + 1);
    check("zero_no_busy", first_busy, -1);
    check("zero_no_aw", aw_seen, 0);

    // Address wrap at the top of the address space.
    run_frame("wrap", AW'((1 << AW) - 512), 40, 0, 1, 1, 70, 2);

    // Randomized frames.
    for (int f = 0; f < 5; f++) begin
      n    = $urandom_range(70, 1);
      nb   = (n + BL - 1) / BL;
      eidx = int'($urandom_range(nb, 0)) - 1;
      base = AW'($urandom) & ~AW'(BL * BYTES - 1);
      run_frame("rand", base, n, $urandom_range(16, 0), 1, $urandom_range(5, 0),
                $urandom_range(100, 30), eidx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr_wr_burst_master.md
# ddr_wr_burst_master

Read-side consumer of the 32→128-bit write FIFO in the DDR write path. Drains 128-bit words from the FIFO read port and issues them to the DDR controller as AXI-style incrementing write bursts. A burst starts only when the FIFO water level covers the whole burst. A frame of `frame_beats` words is written starting at `base_addr`. Runs entirely in the FIFO read-clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 128: FIFO read width and AXI W width.
- `ADDR_WIDTH`, 28: AXI byte address width.
- `LEVEL_WIDTH`, 11: FIFO read water-level width (FIFO read depth width + 1).
- `BURST_LEN`, 16: maximum beats per burst, 1..256.
- `FRAME_WIDTH`, 20: width of `frame_beats`.

Ports:
- `rd_clk` in 1: sole clock.
- `rd_rst` in 1: reset; asynchronous, active-high.
- `start` in 1: one-cycle pulse; latches `base_addr` and `frame_beats`.
- `base_addr` in ADDR_WIDTH: frame start byte address, aligned to BURST_LEN*DATA_WIDTH/8.
- `frame_beats` in FRAME_WIDTH: number of words in the frame.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at frame completion.
- `wr_err` out 1: sticky; set by any non-zero `bresp`; cleared by an accepted `start`.
- `burst_cnt` out 16: completed bursts since `start` (see Configuration).
- `fifo_rd_en` out 1: FIFO read enable.
- `fifo_rd_data` in DATA_WIDTH: FIFO data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_empty` in 1: FIFO empty flag.
- `fifo_rd_water_level` in LEVEL_WIDTH: FIFO read-side level.
- `awaddr` out ADDR_WIDTH: burst address.
- `awlen` out 8: beats minus 1.
- `awvalid` out 1 / `awready` in 1: AW handshake.
- `wdata` out DATA_WIDTH: write data.
- `wlast` out 1: last beat of the burst.
- `wvalid` out 1 / `wready` in 1: W handshake.
- `bresp` in 2: write response code.
- `bvalid` in 1 / `bready` out 1: B handshake.

## Operation
- FSM states: IDLE, WAIT_LVL, ADDR, DATA, RESP.
- IDLE:
  - `start` with `frame_beats`≠0 → WAIT_LVL; latches the address and remaining count, `busy`=1.
  - `start` with `frame_beats`=0 → `done` pulses the next cycle; the FSM stays in IDLE and `busy` stays 0.
  - `start` outside IDLE is ignored.
- Burst size: `blen` = min(BURST_LEN, remaining), computed on entry to WAIT_LVL.
- WAIT_LVL → ADDR when `fifo_rd_water_level` ≥ `blen`.
- ADDR:
  - `awvalid`=1, `awaddr`=current address, `awlen`=`blen`-1, all held stable until `awready`.
  - On handshake → DATA.
  - FIFO prefetch may begin in ADDR.
- Read side:
  - 2-entry output buffer. `fifo_rd_en`=1 only when occupied entries + in-flight reads < 2, reads issued this burst < `blen`, `fifo_rd_empty`=0, and state is ADDR or DATA.
  - Exactly `blen` reads per burst.
- DATA:
  - `wvalid` = buffer non-empty; `wdata` is the buffer head.
  - `wlast`=1 on beat `blen`.
  - After the last W handshake → RESP.
  - Words leave in FIFO order; no gaps are inserted when `wready`=1.
- RESP:
  - `bready`=1. On `bvalid`: `wr_err` |= (`bresp`≠0), remaining -= `blen`, address += `blen`*DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH).
  - Remaining = 0 → IDLE with `done`=1 for one cycle and `busy`=0. Otherwise → WAIT_LVL.
- Reset values: state IDLE; every output 0 (`awaddr`, `awlen`, `wdata`, `burst_cnt` included); buffer emptied; counters cleared.
- Reset mid-burst aborts immediately. Words already read from the FIFO are discarded and no partial burst is completed.

## Timing
- `start` at cycle 0 with sufficient level:
  - WAIT_LVL at cycle 1.
  - `awvalid` at cycle 2.
  - First `fifo_rd_en` at cycle 2.
  - With `awready`=1 at cycle 2, `wvalid` at cycle 3.
- Sustained throughput is 1 beat/cycle with `wready` held at 1.
- Between bursts: `bvalid` handshake at cycle n → WAIT_LVL at n+1 → `awvalid` at n+2 at the earliest.
- `done` asserts the cycle after the final `bvalid` handshake.
- The level compare is registered against the current `fifo_rd_water_level` with no extra pipelining.
- Reset is asynchronous: outputs clear without waiting for a `rd_clk` edge.

## Configuration
- `DDR_WR_BURST_CNT_EN` defined:
  - `burst_cnt` increments on every `bvalid` handshake and clears on an accepted `start`.
  - It saturates at 16'hFFFF.
- Not defined: `burst_cnt` is tied to 0 and no counter logic is built.

## Test plan
- `base_addr`=0x1000, `frame_beats`=32, level=64, ready signals held at 1 → two AW transactions, 0x1000/awlen 15 then 0x1100/awlen 15. 32 W beats in FIFO order with `wlast` on beats 16 and 32. `done` pulses once, one cycle after the second `bvalid`; `burst_cnt`=2 when the macro is defined.
- `frame_beats`=20, `base_addr`=0 → bursts 0x000/awlen 15 and 0x100/awlen 3; exactly 20 `fifo_rd_en` pulses in total.
- Level held at 15 (BURST_LEN 16) → `awvalid` stays 0 indefinitely. Raise the level to 16 → `awvalid` is 1 one cycle later.
- `wready` random 50%, `awready` delayed 5 cycles → no data loss or reordering, at most 2 words outstanding, `wdata`/`wlast` stable while `wvalid`=1 and `wready`=0.
- `bresp`=2'b10 on the first burst of 2 → `wr_err`=1 and the frame still completes. Next `start` → `wr_err`=0.
- Assert `rd_rst` in DATA after 5 beats → all outputs 0 immediately, no `done`. A `start` after release runs a clean frame.
